// File: rtl/cbus_ram_responder.sv
// CBus RAM responder: accepts one request at a time, waits a fixed first-beat
// latency, then streams single or incrementing burst beats out of a
// word-addressed internal RAM (byte-strobed writes, combinational reads).

package cbus_pkg;
  typedef enum logic [3:0] {
    MLEN1  = 4'd0,  MLEN2  = 4'd1,  MLEN3  = 4'd2,  MLEN4  = 4'd3,
    MLEN5  = 4'd4,  MLEN6  = 4'd5,  MLEN7  = 4'd6,  MLEN8  = 4'd7,
    MLEN9  = 4'd8,  MLEN10 = 4'd9,  MLEN11 = 4'd10, MLEN12 = 4'd11,
    MLEN13 = 4'd12, MLEN14 = 4'd13, MLEN15 = 4'd14, MLEN16 = 4'd15
  } cbus_len_t;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    cbus_len_t   len;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;
endpackage

module cbus_ram_responder
  import cbus_pkg::*;
#(
  parameter int DEPTH_WORDS = 4096,
  parameter int LATENCY     = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  cbus_req_t  creq,
  output cbus_resp_t cresp
);

  localparam int         AW       = $clog2(DEPTH_WORDS);
  // Value of the latency counter on the final WAIT cycle.
  localparam logic [3:0] LAT_LAST = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_BURST = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_base;
  logic        r_wr;
  logic [3:0]  r_blen;
  logic [3:0]  r_cnt;
  logic [3:0]  r_lat;
  logic        r_ready;
  logic        r_last;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic [31:0]   w_sum;
  logic [AW-1:0] w_idx;
  logic          w_we;
  logic [31:0]   w_rdata;
  logic          w_unused;

  // Word index wraps modulo the depth; upper address bits simply fall away.
  assign w_sum    = {2'b00, r_base[31:2]} + {28'd0, r_cnt};
  assign w_idx    = w_sum[AW-1:0];
  // A beat coinciding with reset is aborted, so its write is suppressed too.
  assign w_we     = r_ready && r_wr && !reset;
  assign w_rdata  = r_mem[w_idx];
  // size plays no part in addressing or masking; byte lanes come from strobe.
  assign w_unused = &{1'b0, w_sum[31:AW], r_base[1:0], creq.size};

  // Control FSM: accept a request, count out the latency, step the burst beats.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_base  <= 32'h0;
      r_wr    <= 1'b0;
      r_blen  <= 4'd0;
      r_cnt   <= 4'd0;
      r_lat   <= 4'd0;
      r_ready <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (creq.valid) begin
            r_base <= creq.addr;
            r_wr   <= creq.is_write;
            r_blen <= creq.len;
            r_cnt  <= 4'd0;
            r_lat  <= 4'd0;
            if (LATENCY > 0) begin
              r_state <= S_WAIT;
            end else begin
              r_state <= S_BURST;
              r_ready <= 1'b1;
              r_last  <= (creq.len == MLEN1);
            end
          end
        end
        S_WAIT: begin
          if (r_lat == LAT_LAST) begin
            r_state <= S_BURST;
            r_ready <= 1'b1;
            r_last  <= (r_blen == 4'd0);
          end else begin
            r_lat <= r_lat + 4'd1;
          end
        end
        S_BURST: begin
          if (r_cnt == r_blen) begin
            r_state <= S_IDLE;
            r_ready <= 1'b0;
            r_last  <= 1'b0;
          end else begin
            r_cnt  <= r_cnt + 4'd1;
            r_last <= ((r_cnt + 4'd1) == r_blen);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b0;
          r_last  <= 1'b0;
        end
      endcase
    end
  end

  // Byte-strobed RAM write, one word per write-burst beat using live data/strobe.
  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int k = 0; k < 4; k++) begin
        if (creq.strobe[k]) begin
          r_mem[w_idx][8*k +: 8] <= creq.data[8*k +: 8];
        end
      end
    end
  end

  // Response drive: handshake from registered state, read data only on read beats.
  always_comb begin
    cresp.ready = r_ready;
    cresp.last  = r_last;
    if (r_ready && !r_wr) begin
      cresp.data = w_rdata;
    end else begin
      cresp.data = 32'h0;
    end
  end

endmodule

// File: tb/tb_cbus_ram_responder.sv
// Scoreboard bench for cbus_ram_responder: two instances (latency 1 and 0,
// both 16 words deep) driven with directed and random bursts; expected beats
// come from a word-array reference model and are checked by a monitor.

module tb_cbus_ram_responder;
  import cbus_pkg::*;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset;
  cbus_req_t  req  [2];
  cbus_resp_t resp [2];
  int         lat  [2] = '{1, 0};

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int          s;
    logic [31:0] data;
    logic        last;
    int          cyc;
  } exp_t;

  exp_t        exp_q [$];
  exp_t        mon_e;
  logic [31:0] mmem [2][DEPTH];
  logic [31:0] plan_data [16];
  logic [3:0]  plan_strb [16];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cbus_ram_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) u_dut_l1 (
    .clk(clk), .reset(reset), .creq(req[0]), .cresp(resp[0])
  );

  cbus_ram_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(0)) u_dut_l0 (
    .clk(clk), .reset(reset), .creq(req[1]), .cresp(resp[1])
  );

  // Monitor: pop one expected beat per presented beat; police idle outputs.
  always @(negedge clk) begin
    if (!reset) begin
      for (int s = 0; s < 2; s++) begin
        if (resp[s].ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_beat dut=%0d cyc=%0d actual data=%h last=%b required no beat",
                     s, cyc, resp[s].data, resp[s].last);
          end else begin
            mon_e = exp_q.pop_front();
            if (mon_e.s != s || resp[s].data !== mon_e.data || resp[s].last !== mon_e.last ||
                mon_e.cyc != cyc) begin
              errors++;
              $display("FAIL beat dut=%0d actual cyc=%0d data=%h last=%b required dut=%0d cyc=%0d data=%h last=%b",
                       s, cyc, resp[s].data, resp[s].last, mon_e.s, mon_e.cyc, mon_e.data, mon_e.last);
            end
          end
        end else begin
          checks++;
          if (resp[s].last !== 1'b0 || resp[s].data !== 32'h0) begin
            errors++;
            $display("FAIL idle_outputs dut=%0d cyc=%0d actual last=%b data=%h required 0/0",
                     s, cyc, resp[s].last, resp[s].data);
          end
          if (exp_q.size() > 0 && exp_q[0].s == s && exp_q[0].cyc <= cyc) begin
            mon_e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_beat dut=%0d cyc=%0d actual ready=0 required beat data=%h last=%b",
                     s, cyc, mon_e.data, mon_e.last);
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Issue one request on DUT s (DUT idle, called just after a rising edge).
  // Expected beats are derived from the model; rst_beat >= 0 pulses reset on
  // that beat, aborting it and every later beat.
  task automatic run_req(input int s, input bit w, input logic [31:0] a,
                         input int blen, input int rst_beat);
    int          t0;
    int          first;
    int          idx;
    int          nbeats;
    int          k;
    bit          stop;
    logic [31:0] nd;
    nbeats = (rst_beat >= 0 && rst_beat <= blen) ? rst_beat : blen + 1;
    t0     = cyc;
    first  = t0 + 1 + lat[s];
    for (int b = 0; b < nbeats; b++) begin
      idx = (int'(a >> 2) + b) % DEPTH;
      if (w) begin
        nd = mmem[s][idx];
        for (int y = 0; y < 4; y++) begin
          if (plan_strb[b][y]) nd[8*y +: 8] = plan_data[b][8*y +: 8];
        end
        mmem[s][idx] = nd;
        exp_q.push_back('{s, 32'h0, (b == blen), first + b});
      end else begin
        exp_q.push_back('{s, mmem[s][idx], (b == blen), first + b});
      end
    end
    req[s].valid    = 1'b1;
    req[s].is_write = w;
    req[s].addr     = a;
    req[s].len      = cbus_len_t'(4'(blen));
    req[s].size     = 3'($urandom);
    req[s].strobe   = 4'($urandom);
    req[s].data     = $urandom;
    stop = 1'b0;
    for (int c = t0 + 1; c <= first + blen && !stop; c++) begin
      @(posedge clk);
      #1;
      req[s].valid    = 1'($urandom);
      req[s].is_write = 1'($urandom);
      req[s].addr     = $urandom;
      req[s].len      = cbus_len_t'(4'($urandom));
      req[s].size     = 3'($urandom);
      req[s].strobe   = 4'($urandom);
      req[s].data     = $urandom;
      k = c - first;
      if (w && k >= 0) begin
        req[s].data   = plan_data[k];
        req[s].strobe = plan_strb[k];
      end
      if (rst_beat >= 0 && k == rst_beat) begin
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset        = 1'b0;
        req[s].valid = 1'b0;
        stop         = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    req[s].valid = 1'b0;
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp_v);
    end
  endtask

  initial begin
    int s;
    bit w;
    int blen;
    int rb;
    req[0] = '0;
    req[1] = '0;
    reset  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check32("reset_ready", {31'd0, resp[d].ready}, 32'd0);
      check32("reset_last",  {31'd0, resp[d].last},  32'd0);
      check32("reset_data",  resp[d].data,           32'd0);
    end
    @(posedge clk);
    #1;

    // Preload every word of both RAMs with a full 16-beat write.
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 16; k++) begin
        plan_data[k] = $urandom;
        plan_strb[k] = 4'hF;
      end
      run_req(d, 1'b1, 32'h0, 15, -1);
    end

    // Single read: word 0x10 (aliases to word 0 at this depth).
    plan_data[0] = 32'hDEADBEEF;
    plan_strb[0] = 4'hF;
    run_req(0, 1'b1, 32'h40, 0, -1);
    idle(2);
    run_req(0, 1'b0, 32'h40, 0, -1);
    idle(2);

    // Four-beat write then four-beat read of the same words.
    for (int k = 0; k < 4; k++) begin
      plan_data[k] = 32'(k + 1);
      plan_strb[k] = 4'hF;
    end
    run_req(0, 1'b1, 32'h100, 3, -1);
    run_req(0, 1'b0, 32'h100, 3, -1);

    // Partial strobe merge.
    plan_data[0] = 32'h11223344;
    plan_strb[0] = 4'hF;
    run_req(0, 1'b1, 32'h0, 0, -1);
    plan_data[0] = 32'hAABBCCDD;
    plan_strb[0] = 4'b0101;
    run_req(0, 1'b1, 32'h0, 0, -1);
    run_req(0, 1'b0, 32'h0, 0, -1);

    // Back-to-back write then read on the zero-latency instance.
    for (int k = 0; k < 4; k++) begin
      plan_data[k] = $urandom;
      plan_strb[k] = 4'hF;
    end
    run_req(1, 1'b1, 32'h20, 3, -1);
    run_req(1, 1'b0, 32'h20, 3, -1);

    // Reset on beat 3 of an 8-beat write, then read all eight words.
    for (int k = 0; k < 8; k++) begin
      plan_data[k] = $urandom;
      plan_strb[k] = 4'hF;
    end
    run_req(0, 1'b1, 32'h0, 7, 3);
    idle(1);
    run_req(0, 1'b0, 32'h0, 7, -1);

    // Maximum-length burst wrapping past the top of the RAM.
    run_req(0, 1'b0, 32'h38, 15, -1);
    run_req(1, 1'b0, 32'h38, 15, -1);

    // Random traffic, occasional mid-burst reset.
    repeat (60) begin
      s    = int'($urandom % 2);
      w    = 1'($urandom);
      blen = int'($urandom % 16);
      for (int k = 0; k < 16; k++) begin
        plan_data[k] = $urandom;
        plan_strb[k] = 4'($urandom);
      end
      rb = ($urandom % 8 == 0) ? int'($urandom % (blen + 1)) : -1;
      run_req(s, w, $urandom, blen, rb);
      idle(int'($urandom % 3));
    end

    idle(5);
    check32("leftover_beats", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
